// File: rtl/ospi_flash_arbiter_pkg.sv
// Shared types for the two-requester OSPI flash arbiter: op encoding, FSM states, requester count.
package ospi_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_ER_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/ospi_flash_arbiter_if.sv
// Requester handshake and flash command bus; master is the host/flash side, slave is the arbiter.
interface ospi_flash_arbiter_if import ospi_arb_pkg::*; #(parameter int unsigned WIDTH = 8);

    logic [NUM_REQ-1:0]       req_valid;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [NUM_REQ*WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_rdata;
    logic                     rsp_err;
    logic                     busy;
    logic                     write_enable;
    logic                     read_enable;
    logic                     erase_enable;
    logic [WIDTH-1:0]         address;
    logic [WIDTH-1:0]         data_in;
    logic [WIDTH-1:0]         data_out;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  write_enable, read_enable, erase_enable, address, data_in
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output write_enable, read_enable, erase_enable, address, data_in
    );

endinterface

// File: rtl/ospi_flash_arbiter_rr_arbiter.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one that did not win last time wins.
module ospi_rr_arbiter import ospi_arb_pkg::*; (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ospi_flash_arbiter.sv
// Arbiter/sequencer in front of ospi_flash: one strobe per accepted op, one-cycle response to the owner.
// Optional write protection above WP_BASE is compiled in with `define OSPI_ARB_WP_EN.
module ospi_flash_arbiter import ospi_arb_pkg::*; #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      READ_LAT     = 2,
    parameter int unsigned      ERASE_CYCLES = 16,
    parameter logic [WIDTH-1:0] WP_BASE      = 8'hF0
) (
    input  logic               clk,
    input  logic               reset,
    ospi_flash_arbiter_if.slave bus
);

    localparam int unsigned MAX_CYC = (READ_LAT > ERASE_CYCLES) ? READ_LAT : ERASE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] ER_LAST = CNT_W'(ERASE_CYCLES - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0] grant;
    logic               idle;
    logic               hs;
    logic               hs_id;
    logic               wp_block;
    logic               op_err;
    logic               issue;

    ospi_rr_arbiter u_rr (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign idle          = (state_q == ST_IDLE);
    assign bus.req_ready = idle ? grant : '0;
    assign hs            = |(bus.req_valid & bus.req_ready);
    assign hs_id         = grant[1];

`ifdef OSPI_ARB_WP_EN
    assign wp_block = ((op_q == OP_WRITE) || (op_q == OP_ERASE)) && (addr_q >= WP_BASE);
`else
    logic wp_unused;
    assign wp_unused = ^WP_BASE;
    assign wp_block  = 1'b0;
`endif

    // Error ops complete without touching the flash; the same flag is reported in DONE.
    assign op_err = (op_q == OP_RSVD) || wp_block;
    assign issue  = (state_q == ST_ISSUE) && !op_err;

    assign bus.read_enable  = issue && (op_q == OP_READ);
    assign bus.write_enable = issue && (op_q == OP_WRITE);
    assign bus.erase_enable = issue && (op_q == OP_ERASE);
    assign bus.address      = addr_q;
    assign bus.data_in      = wdata_q;
    assign bus.rsp_valid    = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_err      = (state_q == ST_DONE) && op_err;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.busy         = !idle;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    op_d    = op_e'(hs_id ? bus.req_op[3:2] : bus.req_op[1:0]);
                    addr_d  = hs_id ? bus.req_addr[2*WIDTH-1:WIDTH]  : bus.req_addr[WIDTH-1:0];
                    wdata_d = hs_id ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
                    owner_d = hs_id;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (op_err) begin
                    state_d = ST_DONE;
                end else begin
                    case (op_q)
                        OP_READ:  state_d = ST_RD_WAIT;
                        OP_ERASE: state_d = ST_ER_WAIT;
                        default:  state_d = ST_DONE;
                    endcase
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d = bus.data_out;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ER_WAIT: begin
                if (cnt_q == ER_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_READ;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ospi_flash_arbiter.sv
// Directed bench for ospi_flash_arbiter with a small flash model (READ_LAT=2); covers OSPI_ARB_WP_EN either way.
module tb_ospi_flash_arbiter;
    import ospi_arb_pkg::*;

    localparam int unsigned WIDTH = 8;
`ifdef OSPI_ARB_WP_EN
    localparam logic WP_EXP_WE  = 1'b0;
    localparam logic WP_EXP_ERR = 1'b1;
`else
    localparam logic WP_EXP_WE  = 1'b1;
    localparam logic WP_EXP_ERR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ospi_flash_arbiter_if #(.WIDTH(WIDTH)) bus ();

    ospi_flash_arbiter #(
        .WIDTH        (WIDTH),
        .READ_LAT     (2),
        .ERASE_CYCLES (16),
        .WP_BASE      (8'hF0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Flash model: data_out valid two cycles after the read strobe.
    logic [7:0] mem [256];
    logic [7:0] rd_d1 = 8'h00;
    logic [7:0] rd_d2 = 8'h00;
    always @(posedge clk) begin
        if (bus.write_enable) mem[bus.address] <= bus.data_in;
        if (bus.read_enable)  rd_d1 <= mem[bus.address];
        rd_d2 <= rd_d1;
    end
    assign bus.data_out = rd_d2;

    int         er_pulses = 0;
    int         rsp_pulses = 0;
    int         overlap = 0;
    int         wide = 0;
    logic [2:0] strb_now;
    logic [2:0] strb_prev = 3'b000;
    always @(negedge clk) begin
        strb_now = {bus.write_enable, bus.read_enable, bus.erase_enable};
        if ($countones(strb_now) > 1) overlap++;
        if ((strb_now & strb_prev) != 3'b000) wide++;
        strb_prev = strb_now;
        if (bus.erase_enable) er_pulses++;
        if (bus.rsp_valid != 2'b00) rsp_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[id]         = 1'b1;
        bus.req_op[2*id +: 2]     = op;
        bus.req_addr[8*id +: 8]   = a;
        bus.req_wdata[8*id +: 8]  = d;
    endtask

    task automatic idle_req();
        bus.req_valid = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;
        int rsp_base;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        tick(2);
        check_eq("rst_busy",    bus.busy, 0);
        check_eq("rst_ready",   bus.req_ready, 0);
        check_eq("rst_rsp",     bus.rsp_valid, 0);
        check_eq("rst_err",     bus.rsp_err, 0);
        check_eq("rst_strobes", {bus.write_enable, bus.read_enable, bus.erase_enable}, 0);
        check_eq("rst_addr",    bus.address, 0);
        check_eq("rst_din",     bus.data_in, 0);
        check_eq("rst_rdata",   bus.rsp_rdata, 0);

        // Erase aborted by reset five cycles into ER_WAIT
        reset = 1'b0;
        rsp_base = rsp_pulses;
        req(0, OP_ERASE, 8'h10, 8'h00);
        #1;
        check_eq("abort_ready", bus.req_ready, 2'b01);
        tick(1);
        idle_req();
        check_eq("abort_ee", bus.erase_enable, 1);
        check_eq("abort_addr", bus.address, 8'h10);
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_ee_low", bus.erase_enable, 0);
        tick(20);
        check_eq("abort_ee_count", er_pulses, 1);
        check_eq("abort_no_rsp", rsp_pulses - rsp_base, 0);

        // Single write then read back
        req(0, OP_WRITE, 8'h03, 8'hA5);
        #1;
        check_eq("wr_ready", bus.req_ready, 2'b01);
        tick(1);
        idle_req();
        check_eq("wr_we", bus.write_enable, 1);
        check_eq("wr_addr", bus.address, 8'h03);
        check_eq("wr_din", bus.data_in, 8'hA5);
        tick(1);
        check_eq("wr_rsp", bus.rsp_valid, 2'b01);
        check_eq("wr_err", bus.rsp_err, 0);
        tick(1);
        check_eq("wr_idle", bus.busy, 0);
        req(0, OP_READ, 8'h03, 8'h00);
        tick(1);
        idle_req();
        check_eq("rd_re", bus.read_enable, 1);
        tick(2);
        check_eq("rd_rsp_early", bus.rsp_valid, 2'b00);
        tick(1);
        check_eq("rd_rsp", bus.rsp_valid, 2'b01);
        check_eq("rd_data", bus.rsp_rdata, 8'hA5);
        tick(1);

        // Reserved op from requester 1
        req(1, OP_RSVD, 8'h55, 8'h00);
        #1;
        check_eq("rsvd_ready", bus.req_ready, 2'b10);
        tick(1);
        idle_req();
        check_eq("rsvd_strobes", {bus.write_enable, bus.read_enable, bus.erase_enable}, 0);
        tick(1);
        check_eq("rsvd_rsp", bus.rsp_valid, 2'b10);
        check_eq("rsvd_err", bus.rsp_err, 1);
        tick(1);

        // Both requesters write continuously; last winner was 1, so 0 goes first
        req(0, OP_WRITE, 8'h40, 8'h11);
        req(1, OP_WRITE, 8'h41, 8'h22);
        #1;
        for (int i = 0; i < 10; i++) begin
            check_eq("rr_ready", bus.req_ready,
                     (i % 3 != 0) ? 2'b00 : (((i / 3) % 2) != 0 ? 2'b10 : 2'b01));
            if (i % 3 == 1) begin
                check_eq("rr_we", bus.write_enable, 1);
                check_eq("rr_addr", bus.address, (((i / 3) % 2) != 0) ? 8'h41 : 8'h40);
            end
            tick(1);
        end
        idle_req();
        check_eq("rr_we_last", bus.write_enable, 1);
        check_eq("rr_addr_last", bus.address, 8'h41);
        tick(2);

        // Erase from requester 1 holds off a read from requester 0
        req(1, OP_ERASE, 8'h20, 8'h00);
        #1;
        check_eq("er_ready", bus.req_ready, 2'b10);
        tick(1);
        idle_req();
        check_eq("er_ee", bus.erase_enable, 1);
        tick(1);
        req(0, OP_READ, 8'h03, 8'h00);
        #1;
        early = 0;
        for (int k = 2; k < 18; k++) begin
            if (bus.req_ready != 2'b00 || bus.rsp_valid != 2'b00) early++;
            tick(1);
        end
        check_eq("er_hold", early, 0);
        check_eq("er_rsp", bus.rsp_valid, 2'b10);
        check_eq("er_ready_done", bus.req_ready, 2'b00);
        tick(1);
        check_eq("er_ready_after", bus.req_ready, 2'b01);
        tick(1);
        idle_req();
        tick(3);
        check_eq("er_rd_rsp", bus.rsp_valid, 2'b01);
        check_eq("er_rd_data", bus.rsp_rdata, 8'hA5);
        tick(1);

        // Write-protect boundary
        req(0, OP_WRITE, 8'hF4, 8'h3C);
        tick(1);
        idle_req();
        check_eq("wp_hi_we", bus.write_enable, WP_EXP_WE);
        tick(1);
        check_eq("wp_hi_rsp", bus.rsp_valid, 2'b01);
        check_eq("wp_hi_err", bus.rsp_err, WP_EXP_ERR);
        tick(1);
        req(0, OP_WRITE, 8'hEF, 8'h3D);
        tick(1);
        idle_req();
        check_eq("wp_lo_we", bus.write_enable, 1);
        tick(1);
        check_eq("wp_lo_rsp", bus.rsp_valid, 2'b01);
        check_eq("wp_lo_err", bus.rsp_err, 0);
        tick(2);

        check_eq("no_overlap", overlap, 0);
        check_eq("one_cycle_strobes", wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
